irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- External-interrupt aggregator sitting directly upstream of the machine-mode CSR/privilege unit.
- Collects NSRC peripheral interrupt lines (UART, SD, PS/2, …) through per-source gateways into pending bits, masks them with an enable register, and drives the single m_eip level into the privilege unit.
- Auto-claims the winning source on the m_eip_reply pulse and holds m_eip low until software completes the claim over the MMIO bus.

Parameters:
- NSRC, 8, number of interrupt sources (1..31); source i has ID i+1, ID 0 = none.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- irq_src  in  NSRC  raw peripheral interrupt lines
- a  in  3  register word index
- d  in  32  write data
- we  in  1  write strobe, single cycle
- spo  out  32  combinational read data for index a
- m_eip  out  1  registered external-interrupt request level to privilege unit
- m_eip_reply  in  1  single-cycle pulse from privilege unit when it issues the interrupt to the CPU

Behaviour:
- Register map (a), unused bits read 0:
  - 0 PENDING: RO, [NSRC-1:0]
  - 1 ENABLE: RW
  - 2 EDGE: RW; 1 = edge-triggered, 0 = level
  - 3 CLAIM: read returns {27'b0, claim_id}; write completes
  - 4 STATUS: RO, bit0 = state==CLAIMED
  - 5..7 read 0, writes ignored
- Reset values: PENDING, ENABLE, EDGE, claim_id = 0; state = IDLE; m_eip = 0; edge-detect history = 0.
- Gateway, per source i, evaluated each cycle:
  - Edge mode: a rising edge (src & ~src_prev) sets pending[i].
  - Level mode: src high sets pending[i] unless state==CLAIMED and claim_id==i+1. This blocks re-pend while the source is in flight.
  - A set and a clear in the same cycle: set wins, so the event is not lost.
- State machine:
  - IDLE:
    - m_eip <= |(PENDING & ENABLE).
    - On m_eip_reply: win = lowest index with pending&enable. If win exists: claim_id <= win+1, clear pending[win], m_eip <= 0, go CLAIMED. If none (enable cleared meanwhile): claim_id <= 0, stay IDLE.
  - CLAIMED:
    - m_eip <= 0.
    - m_eip_reply is ignored.
    - Write to CLAIM with d[4:0]==claim_id: claim_id <= 0, go IDLE.
    - A mismatched-ID write is ignored.
- Latency:
  - Edge/level at cycle 0 → pending set at edge 1 → m_eip high at edge 2.
  - After complete, m_eip re-evaluates one cycle after state returns to IDLE.
- Other boundary rules:
  - ENABLE write takes effect on m_eip at the next edge. Disabled sources still latch pending.
  - Writing EDGE does not clear pending.
  - Writing CLAIM in IDLE: no effect.
  - rst mid-claim: everything returns to reset values. Level sources re-pend after reset if still high and later enabled.
  - m_eip_reply and a CLAIM write in the same cycle: CLAIM write processed in CLAIMED; reply ignored.

Optional Feature:
- IRQ_CTRL_SYNC_EN
  - Defined: each irq_src passes a 2-flop synchronizer (reset 0) before the gateway. Source-to-m_eip latency becomes 4 cycles.
  - Undefined: irq_src feeds the gateway directly. Sources must already be synchronous to clk; latency is 2 cycles.

Decomposition:
- Package irq_ctrl_pkg:
  - Register indices REG_PENDING..REG_STATUS
  - ID width constant (5)
  - State encoding IDLE/CLAIMED
  - ID_NONE = 0
- Sub-module irq_gateway (one per source, generate loop):
  - Inputs: src, edge_mode, in_flight, clr.
  - Output: pending bit.
  - Owns the optional synchronizer and edge history.
- Top level owns ENABLE/EDGE registers, the priority encoder, the FSM, and read muxing.

Test Plan:
- Edge fire: ENABLE=0x04, EDGE=0x04, 1-cycle pulse on src[2] → PENDING=0x04, m_eip=1 two cycles later; reply pulse → claim_id=3, PENDING=0, m_eip=0; write CLAIM=3 → STATUS=0.
- Priority: ENABLE=0xFF, src[5] and src[1] rise same cycle → reply claims ID 2; after complete, m_eip reasserts; next reply claims ID 6.
- Level hold: EDGE=0, src[0] held high through claim → no re-pend while CLAIMED, PENDING=0; write CLAIM=1 → PENDING=0x01 and m_eip=1 again.
- Masking/spurious: src[3] edge with ENABLE=0 → PENDING=0x08, m_eip=0; reply pulse → claim_id=0, state IDLE; set ENABLE=0x08 → m_eip=1 next edge.
- Wrong complete and reset: claim ID 4, write CLAIM=2 → still CLAIMED, m_eip=0; assert rst → all registers 0, m_eip=0, STATUS=0.
- With IRQ_CTRL_SYNC_EN: edge on src[0] → m_eip high exactly 4 cycles later.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// irq_ctrl_pkg
//   Shared definitions for the external-interrupt aggregator.
//   - Register word indices of the MMIO map
//   - Width of a source ID and the "no source" ID
//   - Claim state machine encoding
// ----------------------------------------------------------------------------
package irq_ctrl_pkg;

    // MMIO word indices (3-bit address a)
    localparam logic [2:0] REG_PENDING = 3'd0;
    localparam logic [2:0] REG_ENABLE  = 3'd1;
    localparam logic [2:0] REG_EDGE    = 3'd2;
    localparam logic [2:0] REG_CLAIM   = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;

    // Source IDs: source i reports ID i+1, ID 0 means "none"
    localparam int              ID_W    = 5;
    localparam logic [ID_W-1:0] ID_NONE = '0;

    typedef enum logic {
        IDLE    = 1'b0,
        CLAIMED = 1'b1
    } irq_state_t;

endpackage : irq_ctrl_pkg

// File: rtl/irq_gateway.sv
// ----------------------------------------------------------------------------
// irq_gateway
//   Per-source gateway: turns one raw interrupt line into a pending bit.
//   Optional macro IRQ_CTRL_SYNC_EN inserts a 2-flop synchronizer in front
//   of the edge/level detection (adds two cycles of latency).
//
// Ports
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   src_i        in   raw interrupt line
//   edge_mode_i  in   1 = rising-edge triggered, 0 = level triggered
//   in_flight_i  in   this source is currently being claimed / serviced
//   clr_i        in   clear the pending bit (source won the claim)
//   pending_o    out  pending bit
// ----------------------------------------------------------------------------
module irq_gateway (
    input  logic clk,
    input  logic rst,
    input  logic src_i,
    input  logic edge_mode_i,
    input  logic in_flight_i,
    input  logic clr_i,
    output logic pending_o
);

    logic src_s;

`ifdef IRQ_CTRL_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], src_i};
        end
    end

    assign src_s = sync_q[1];
`else
    assign src_s = src_i;
`endif

    logic prev_q;
    logic pending_q;
    logic pending_d;
    logic set;

    // A level source that is in flight must not re-pend until the claim
    // is completed, otherwise it would fire again immediately.
    assign set = edge_mode_i ? (src_s & ~prev_q) : (src_s & ~in_flight_i);

    // Set has priority over clear so a new event arriving in the claim
    // cycle is not lost.
    always_comb begin
        pending_d = pending_q;
        if (clr_i) begin
            pending_d = 1'b0;
        end
        if (set) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            prev_q    <= src_s;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule : irq_gateway

// File: rtl/irq_ctrl.sv
// ----------------------------------------------------------------------------
// irq_ctrl
//   External-interrupt aggregator feeding the machine-mode privilege unit.
//   NSRC gateways produce pending bits; pending & ENABLE drives m_eip.
//   On m_eip_reply the lowest-index enabled pending source is auto-claimed
//   and m_eip is held low until software writes the matching ID to CLAIM.
//   Optional macro IRQ_CTRL_SYNC_EN: synchronize irq_src inside the
//   gateways (source-to-m_eip latency 4 cycles instead of 2).
//
// Ports
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   irq_src      in   [NSRC] raw interrupt lines
//   a            in   [3]    register word index
//   d            in   [32]   write data
//   we           in   write strobe
//   spo          out  [32]   combinational read data for index a
//   m_eip        out  registered external-interrupt request
//   m_eip_reply  in   one-cycle pulse: privilege unit took the interrupt
//
// Register map: 0 PENDING (RO), 1 ENABLE, 2 EDGE, 3 CLAIM, 4 STATUS (RO).
// ----------------------------------------------------------------------------
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic [2:0]      a,
    input  logic [31:0]     d,
    input  logic            we,
    output logic [31:0]     spo,
    output logic            m_eip,
    input  logic            m_eip_reply
);

    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] active;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] in_flight;

    logic [NSRC-1:0] enable_q, enable_d;
    logic [NSRC-1:0] edge_q,   edge_d;

    irq_state_t      state_q;
    logic [ID_W-1:0] claim_id_q;
    logic            m_eip_q;

    logic [ID_W-1:0] win_id;
    logic            claim_take;
    logic            claim_done;

    // Write data bits above the implemented fields are don't-care.
    logic unused_d;
    assign unused_d = ^d;

    // Lowest index wins; returns the ID (index+1) or ID_NONE.
    function automatic logic [ID_W-1:0] lowest_id(input logic [NSRC-1:0] v);
        lowest_id = ID_NONE;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_id = ID_W'(i + 1);
            end
        end
    endfunction

    assign active     = pending & enable_q;
    assign win_id     = lowest_id(active);
    assign claim_take = (state_q == IDLE) && m_eip_reply && (win_id != ID_NONE);
    assign claim_done = (state_q == CLAIMED) && we && (a == REG_CLAIM) &&
                        (d[ID_W-1:0] == claim_id_q);

    // The claim cycle itself already counts as in flight, so a level source
    // that stays high is not re-pended by the set-over-clear rule.
    for (genvar i = 0; i < NSRC; i++) begin : g_src
        assign clr[i]       = claim_take && (win_id == ID_W'(i + 1));
        assign in_flight[i] = ((state_q == CLAIMED) && (claim_id_q == ID_W'(i + 1)))
                              || clr[i];

        irq_gateway u_gw (
            .clk         (clk),
            .rst         (rst),
            .src_i       (irq_src[i]),
            .edge_mode_i (edge_q[i]),
            .in_flight_i (in_flight[i]),
            .clr_i       (clr[i]),
            .pending_o   (pending[i])
        );
    end

    always_comb begin
        enable_d = enable_q;
        edge_d   = edge_q;
        if (we && (a == REG_ENABLE)) begin
            enable_d = d[NSRC-1:0];
        end
        if (we && (a == REG_EDGE)) begin
            edge_d = d[NSRC-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q <= '0;
            edge_q   <= '0;
        end else begin
            enable_q <= enable_d;
            edge_q   <= edge_d;
        end
    end

    // Claim state machine; m_eip and claim_id are registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            claim_id_q <= ID_NONE;
            m_eip_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    m_eip_q <= |active;
                    if (m_eip_reply) begin
                        if (win_id != ID_NONE) begin
                            claim_id_q <= win_id;
                            m_eip_q    <= 1'b0;
                            state_q    <= CLAIMED;
                        end else begin
                            // Spurious reply: enable was dropped meanwhile.
                            claim_id_q <= ID_NONE;
                        end
                    end
                end
                CLAIMED: begin
                    m_eip_q <= 1'b0;
                    if (claim_done) begin
                        claim_id_q <= ID_NONE;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_eip = m_eip_q;

    always_comb begin
        spo = '0;
        case (a)
            REG_PENDING: spo = {{(32 - NSRC){1'b0}}, pending};
            REG_ENABLE:  spo = {{(32 - NSRC){1'b0}}, enable_q};
            REG_EDGE:    spo = {{(32 - NSRC){1'b0}}, edge_q};
            REG_CLAIM:   spo = {{(32 - ID_W){1'b0}}, claim_id_q};
            REG_STATUS:  spo = {31'b0, (state_q == CLAIMED)};
            default:     spo = '0;
        endcase
    end

endmodule : irq_ctrl

// File: tb/tb_irq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_irq_ctrl
//   Directed, table-driven bench for irq_ctrl (NSRC = 8). Each vector drives
//   inputs for one clock edge, then reads one register and m_eip.
//   Build with IRQ_CTRL_SYNC_EN defined to exercise the synchronized path.
// ----------------------------------------------------------------------------
module tb_irq_ctrl;

    localparam int NSRC = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NSRC-1:0] irq_src;
    logic [2:0]      a;
    logic [31:0]     d;
    logic            we;
    logic [31:0]     spo;
    logic            m_eip;
    logic            m_eip_reply;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    irq_ctrl #(.NSRC(NSRC)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_src     (irq_src),
        .a           (a),
        .d           (d),
        .we          (we),
        .spo         (spo),
        .m_eip       (m_eip),
        .m_eip_reply (m_eip_reply)
    );

    typedef struct {
        logic [7:0]  src;
        logic        reply;
        logic        we;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [31:0] exp_rd;
        logic        chk_eip;
        logic        exp_eip;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [7:0] src, input logic rep,
                                input logic w, input logic [2:0] wa,
                                input logic [31:0] wd, input logic [2:0] ra,
                                input logic [31:0] er, input logic ce,
                                input logic ee);
        vec_t v;
        v.src = src; v.reply = rep; v.we = w; v.wa = wa; v.wd = wd;
        v.ra = ra; v.exp_rd = er; v.chk_eip = ce; v.exp_eip = ee;
        return v;
    endfunction

    task automatic chk(input int idx, input logic [2:0] what,
                       input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            if (what == 3'd7)
                $display("FAIL v%0d m_eip: got %0h expected %0h", idx, act, exp_v);
            else
                $display("FAIL v%0d spo[a=%0d]: got 0x%08h expected 0x%08h",
                         idx, what, act, exp_v);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        irq_src     = v.src;
        m_eip_reply = v.reply;
        we          = v.we;
        a           = v.wa;
        d           = v.wd;
        @(posedge clk);
        #1;
        m_eip_reply = 1'b0;
        we          = 1'b0;
        a           = v.ra;
        #1;
        chk(idx, v.ra, spo, v.exp_rd);
        if (v.chk_eip) chk(idx, 3'd7, {31'b0, m_eip}, {31'b0, v.exp_eip});
    endtask

    task automatic check_all_zero(input int idx);
        for (int r = 0; r < 5; r++) begin
            a = 3'(r);
            #1;
            chk(idx, 3'(r), spo, 32'h0);
        end
        chk(idx, 3'd7, {31'b0, m_eip}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; irq_src = '0; a = '0; d = '0; we = 1'b0; m_eip_reply = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all_zero(900);

`ifdef IRQ_CTRL_SYNC_EN
        apply(mk(8'h00, 0, 1, 3'd1, 32'h1, 3'd1, 32'h1, 1, 0), 0);
        apply(mk(8'h00, 0, 1, 3'd2, 32'h1, 3'd2, 32'h1, 1, 0), 1);
        // Edge on src[0]: m_eip must rise exactly at the fourth edge.
        @(negedge clk);
        irq_src = 8'h01;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            irq_src = 8'h00;
            chk(100 + k, 3'd7, {31'b0, m_eip}, {31'b0, (k == 4)});
        end
`else
        // Edge fire on src[2]
        vq.push_back(mk(8'h00, 0, 1, 3'd1, 32'h04, 3'd1, 32'h04, 1, 0));
        vq.push_back(mk(8'h00, 0, 1, 3'd2, 32'h04, 3'd2, 32'h04, 1, 0));
        vq.push_back(mk(8'h04, 0, 0, 3'd0, 32'h00, 3'd0, 32'h04, 1, 0));
        vq.push_back(mk(8'h00, 0, 0, 3'd0, 32'h00, 3'd0, 32'h04, 1, 1));
        vq.push_back(mk(8'h00, 1, 0, 3'd0, 32'h00, 3'd3, 32'h03, 1, 0));
        vq.push_back(mk(8'h00, 0, 0, 3'd0, 32'h00, 3'd0, 32'h00, 1, 0));
        vq.push_back(mk(8'h00, 0, 0, 3'd0, 32'h00, 3'd4, 32'h01, 1, 0));
        vq.push_back(mk(8'h00, 0, 1, 3'd3, 32'h03, 3'd4, 32'h00, 1, 0));
        vq.push_back(mk(8'h00, 0, 0, 3'd0, 32'h00, 3'd3, 32'h00, 1, 0));
        vq.push_back(mk(8'h00, 0, 1, 3'd3, 32'h05, 3'd4, 32'h00, 1, 0));
        // Priority: src[5] and src[1] together
        vq.push_back(mk(8'h00, 0, 1, 3'd1, 32'hFF, 3'd1, 32'hFF, 1, 0));
        vq.push_back(mk(8'h00, 0, 1, 3'd2, 32'hFF, 3'd2, 32'hFF, 1, 0));
        vq.push_back(mk(8'h22, 0, 0, 3'd0, 32'h00, 3'd0, 32'h22, 1, 0));
        vq.push_back(mk(8'h00, 0, 0, 3'd0, 32'h00, 3'd0, 32'h22, 1, 1));
        vq.push_back(mk(8'h00, 1, 0, 3'd0, 32'h00, 3'd3, 32'h02, 1, 0));
        vq.push_back(mk(8'h00, 0, 0, 3'd0, 32'h00, 3'd0, 32'h20, 1, 0));
        vq.push_back(mk(8'h00, 0, 1, 3'd3, 32'h02, 3'd4, 32'h00, 1, 0));
        vq.push_back(mk(8'h00, 0, 0, 3'd0, 32'h00, 3'd3, 32'h00, 1, 1));
        vq.push_back(mk(8'h00, 1, 0, 3'd0, 32'h00, 3'd3, 32'h06, 1, 0));
        vq.push_back(mk(8'h00, 1, 1, 3'd3, 32'h06, 3'd4, 32'h00, 1, 0));
        vq.push_back(mk(8'h00, 0, 0, 3'd0, 32'h00, 3'd0, 32'h00, 1, 0));
        // Level hold on src[0]
        vq.push_back(mk(8'h00, 0, 1, 3'd2, 32'h00, 3'd2, 32'h00, 1, 0));
        vq.push_back(mk(8'h00, 0, 1, 3'd1, 32'h01, 3'd1, 32'h01, 1, 0));
        vq.push_back(mk(8'h01, 0, 0, 3'd0, 32'h00, 3'd0, 32'h01, 1, 0));
        vq.push_back(mk(8'h01, 0, 0, 3'd0, 32'h00, 3'd0, 32'h01, 1, 1));
        vq.push_back(mk(8'h01, 1, 0, 3'd0, 32'h00, 3'd0, 32'h00, 1, 0));
        vq.push_back(mk(8'h01, 0, 0, 3'd0, 32'h00, 3'd0, 32'h00, 1, 0));
        vq.push_back(mk(8'h01, 0, 1, 3'd3, 32'h01, 3'd0, 32'h00, 1, 0));
        vq.push_back(mk(8'h01, 0, 0, 3'd0, 32'h00, 3'd0, 32'h01, 1, 0));
        vq.push_back(mk(8'h01, 0, 0, 3'd0, 32'h00, 3'd0, 32'h01, 1, 1));
        vq.push_back(mk(8'h00, 1, 0, 3'd0, 32'h00, 3'd3, 32'h01, 1, 0));
        vq.push_back(mk(8'h00, 0, 1, 3'd3, 32'h01, 3'd0, 32'h00, 1, 0));
        vq.push_back(mk(8'h00, 0, 0, 3'd0, 32'h00, 3'd0, 32'h00, 1, 0));
        // Masking and spurious reply on src[3]
        vq.push_back(mk(8'h00, 0, 1, 3'd1, 32'h00, 3'd1, 32'h00, 1, 0));
        vq.push_back(mk(8'h00, 0, 1, 3'd2, 32'h08, 3'd2, 32'h08, 1, 0));
        vq.push_back(mk(8'h08, 0, 0, 3'd0, 32'h00, 3'd0, 32'h08, 1, 0));
        vq.push_back(mk(8'h00, 0, 0, 3'd0, 32'h00, 3'd0, 32'h08, 1, 0));
        vq.push_back(mk(8'h00, 1, 0, 3'd0, 32'h00, 3'd4, 32'h00, 1, 0));
        vq.push_back(mk(8'h00, 0, 0, 3'd0, 32'h00, 3'd3, 32'h00, 1, 0));
        vq.push_back(mk(8'h00, 0, 1, 3'd2, 32'h00, 3'd0, 32'h08, 1, 0));
        vq.push_back(mk(8'h00, 0, 1, 3'd1, 32'h08, 3'd1, 32'h08, 0, 0));
        vq.push_back(mk(8'h00, 0, 0, 3'd0, 32'h00, 3'd0, 32'h08, 1, 1));
        // Wrong-ID complete, unused registers
        vq.push_back(mk(8'h00, 1, 0, 3'd0, 32'h00, 3'd3, 32'h04, 1, 0));
        vq.push_back(mk(8'h00, 0, 1, 3'd3, 32'h02, 3'd4, 32'h01, 1, 0));
        vq.push_back(mk(8'h00, 0, 0, 3'd0, 32'h00, 3'd3, 32'h04, 1, 0));
        vq.push_back(mk(8'h00, 0, 1, 3'd5, 32'hFFFFFFFF, 3'd5, 32'h00, 1, 0));
        vq.push_back(mk(8'h00, 0, 0, 3'd0, 32'h00, 3'd7, 32'h00, 1, 0));

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], i);
        end

        // Reset mid-claim with src[0] held high
        @(negedge clk);
        rst     = 1'b1;
        irq_src = 8'h01;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all_zero(200);
        @(posedge clk);
        #1;
        a = 3'd0;
        #1;
        chk(201, 3'd0, spo, 32'h01);
        chk(201, 3'd7, {31'b0, m_eip}, 32'h0);
        apply(mk(8'h01, 0, 1, 3'd1, 32'h01, 3'd1, 32'h01, 0, 0), 202);
        apply(mk(8'h01, 0, 0, 3'd0, 32'h00, 3'd0, 32'h01, 1, 1), 203);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_irq_ctrl
